fib_seq_param: RTL and testbench
================================

# fib_seq_param

- Parametrised Fibonacci sequence engine with two modes:
  - **Limit mode:** returns the largest Fibonacci term not exceeding an input bound.
  - **Index mode:** returns the n-th term.
- Configurable data width; reports the term index and an overflow flag.
- Start/Busy/Done handshake with a one-cycle Done pulse.
- Optional per-term output stream for downstream consumers.
- Sits beside the existing sequence generators as their width-generic successor; consumers poll Done or watch the term stream.

## Interface
- WIDTH, 10, bit width of Number, Result, Term
- IDXW, 6, width of Count; must satisfy 2^IDXW-1 ≥ index of largest term fitting in WIDTH bits
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only while idle
- Mode  in  1  0 = limit mode, 1 = index mode
- Number  in  WIDTH  bound (limit) or index n (index)
- Busy  out  1  high while an operation is in progress
- Done  out  1  one-cycle completion pulse
- Result  out  WIDTH  final term F(K)
- Count  out  IDXW  index K of Result (F(0)=0, F(1)=1, F(2)=1, …)
- Overflow  out  1  index mode only: F(n) not representable in WIDTH bits
- TermValid  out  1  stream strobe (see Configuration)
- Term  out  WIDTH  stream term value

## Operation
- **Reset:** Rst_n low forces the following immediately, regardless of Clk:
  - state IDLE
  - Busy, Done, Result, Count, Overflow, TermValid, Term all 0
- **States:**
  - IDLE → INIT on a Start-accept edge (Start=1).
  - INIT → STEP unconditionally.
  - STEP → STEP while advancing; STEP → IDLE on termination.
- **Start accept:** registers Mode and Number internally. Changes on either input while Busy are ignored, and Start while Busy is ignored.
- **INIT:** Cur=0, Nxt=1, k=0.
- **STEP datapath:**
  - Sum = Cur+Nxt is computed in WIDTH+1 bits; NxtOvf is set if Nxt ever exceeds 2^WIDTH-1.
  - Advance means Cur←Nxt, Nxt←Sum, k←k+1.
- **Limit-mode termination:** terminate when NxtOvf=1 or Nxt > Number; otherwise advance. Overflow stays 0 in limit mode.
- **Index-mode termination:**
  - k == n: terminate with Overflow=0.
  - else if NxtOvf=1: terminate with Overflow=1.
  - else advance.
- **On termination:** the same edge registers Result=Cur, Count=k and Overflow, pulses Done, clears Busy and returns the state to IDLE.
- Result, Count and Overflow hold their values until the next termination; they are not cleared by Start.

## Timing
- Start-accept edge = edge 0; Busy rises after edge 0.
- STEP with k=j occupies the cycle after edge j+1.
- Final index K: Done rises and Busy falls after edge K+2; Done falls after edge K+3. Latency = K+3 cycles.
- Start high during the Done cycle is accepted (state is IDLE); back-to-back operations are separated by no idle cycle.
- Reset mid-operation aborts the operation; no Done is issued.

## Configuration
- **FIB_SEQ_STREAM_EN defined:**
  - TermValid = 1 in every STEP cycle, with Term = Cur; both are combinational from the state and Cur registers.
  - Each term F(0)…F(K) is presented exactly once, in order.
- **FIB_SEQ_STREAM_EN undefined:** TermValid and Term are tied to 0, and the stream logic is absent. All other behaviour is identical.

## Test plan
- **Limit mode, small bound:** Mode=0, Number=10 → Result=8, Count=6, Overflow=0; Done high only after edge 8, Busy high after edges 0–7.
- **Limit mode, edge bounds:** Number=0 → Result=0, Count=0, Done after edge 2. Number=1 → Result=1, Count=2.
- **Index mode, WIDTH=10:**
  - Number=16 → Result=987, Count=16, Overflow=0.
  - Number=17 → Result=987, Count=16, Overflow=1.
  - Limit mode with Number=1023 → Result=987, Count=16, Overflow=0 (no wrap).
- **Handshake:**
  - Start pulsed during Busy → ignored.
  - Number changed mid-operation → no effect.
  - Start asserted in the Done cycle with Mode=1, Number=5 → accepted; Result=5, Count=5 after edge 7 of the new operation.
- **Reset mid-operation:** Mode=1, Number=12; drop Rst_n asynchronously after edge 4 → all outputs 0 before the next Clk edge, no Done. After release, Number=12 → Result=144, Count=12.
- **Stream (FIB_SEQ_STREAM_EN defined):** Mode=0, Number=10 → exactly 7 TermValid cycles carrying 0,1,1,2,3,5,8. With the macro undefined, TermValid stays 0 throughout.

Source files
------------

// File: rtl/fib_seq_param.sv
// Width-generic Fibonacci engine: limit mode (largest term <= bound) or index mode (n-th term).
// Define FIB_SEQ_STREAM_EN to expose the per-term stream on term_valid/term.
module fib_seq_param #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned IDXW  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [IDXW-1:0]  count,
  output logic             overflow,
  output logic             term_valid,
  output logic [WIDTH-1:0] term
);

  localparam int unsigned CMPW = (WIDTH > IDXW) ? WIDTH : IDXW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_ovf;
  logic [IDXW-1:0]  k;

  logic [WIDTH:0]   sum;
  logic             idx_hit;
  logic             limit_stop;
  logic             stop;

  // One extra sum bit flags a successor that no longer fits in WIDTH bits
  assign sum        = {1'b0, cur} + {1'b0, nxt};
  assign idx_hit    = (CMPW'(k) == CMPW'(num_q));
  assign limit_stop = nxt_ovf || (nxt > num_q);
  assign stop       = mode_q ? (idx_hit || nxt_ovf) : limit_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      num_q    <= '0;
      cur      <= '0;
      nxt      <= '0;
      nxt_ovf  <= 1'b0;
      k        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            num_q  <= number;
            busy   <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          cur     <= '0;
          nxt     <= WIDTH'(1);
          nxt_ovf <= 1'b0;
          k       <= '0;
          state   <= STEP;
        end
        STEP: begin
          if (stop) begin
            // Overflow only when index mode ran out of representable terms
            result   <= cur;
            count    <= k;
            overflow <= mode_q & ~idx_hit;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cur     <= nxt;
            nxt     <= sum[WIDTH-1:0];
            nxt_ovf <= sum[WIDTH];
            k       <= k + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIB_SEQ_STREAM_EN
  // Each STEP cycle presents the current term exactly once
  assign term_valid = (state == STEP);
  assign term       = (state == STEP) ? cur : '0;
`else
  assign term_valid = 1'b0;
  assign term       = '0;
`endif

endmodule

// File: tb/tb_fib_seq_param.sv
// Randomized bench for fib_seq_param against a term-table reference model.
// Stream checks follow FIB_SEQ_STREAM_EN.
module tb_fib_seq_param;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned IDXW  = 6;
  localparam int          MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [IDXW-1:0]  count;
  logic             overflow;
  logic             term_valid;
  logic [WIDTH-1:0] term;

  int n_cmp;
  int n_err;
  int fib[0:63];
  int last_idx;

  fib_seq_param #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .number(number),
    .busy(busy), .done(done), .result(result), .count(count),
    .overflow(overflow), .term_valid(term_valid), .term(term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Table of every Fibonacci term representable in WIDTH bits
  task automatic build_table();
    fib[0] = 0;
    fib[1] = 1;
    last_idx = 1;
    while (fib[last_idx] + fib[last_idx-1] <= MAXV) begin
      fib[last_idx+1] = fib[last_idx] + fib[last_idx-1];
      last_idx++;
    end
  endtask

  function automatic void model(input logic m, input int n, output int r, output int k, output int ov);
    ov = 0;
    if (m) begin
      if (n <= last_idx) k = n;
      else begin
        k  = last_idx;
        ov = 1;
      end
    end else begin
      k = 0;
      for (int i = 0; i <= last_idx; i++)
        if (fib[i] <= n) k = i;
    end
    r = fib[k];
  endfunction

  // Called #1 after a posedge; leaves #1 after the Done edge so a following call is back-to-back
  task automatic do_op(input logic m, input int n, input bit glitch);
    int er, ek, eo, edge_done, tv_cnt;
    int sq[$];
    model(m, n, er, ek, eo);
    edge_done = ek + 2;
    tv_cnt = 0;
    mode   = m;
    number = WIDTH'(n);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j <= edge_done; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      chk("busy", 32'(busy), 32'(j < edge_done));
      chk("done", 32'(done), 32'(j == edge_done));
      if (term_valid) begin
        tv_cnt++;
        sq.push_back(int'(term));
      end
      if (glitch && j == 1) begin
        start  = 1'b1;
        number = ~number;
        mode   = ~mode;
      end
      if (glitch && j == 2) start = 1'b0;
    end
    chk("result", 32'(result), 32'(er));
    chk("count", 32'(count), 32'(ek));
    chk("overflow", 32'(overflow), 32'(eo));
`ifdef FIB_SEQ_STREAM_EN
    chk("tv_cnt", 32'(tv_cnt), 32'(ek + 1));
    foreach (sq[i]) if (i <= ek) chk("term", 32'(sq[i]), 32'(fib[i]));
`else
    chk("tv_off", 32'(tv_cnt), 32'd0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_tv"}, 32'(term_valid), 32'd0);
    chk({tag, "_term"}, 32'(term), 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    build_table();
    rst_n  = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    number = '0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, issued back-to-back
    do_op(1'b0, 10, 1'b0);
    do_op(1'b0, 0, 1'b0);
    do_op(1'b0, 1, 1'b0);
    do_op(1'b1, 16, 1'b0);
    do_op(1'b1, 17, 1'b0);
    do_op(1'b0, 1023, 1'b0);
    do_op(1'b1, 9, 1'b1);
    do_op(1'b0, 500, 1'b1);
    do_op(1'b1, 5, 1'b0);
    @(posedge clk); #1;
    chk("done_fall", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    mode   = 1'b1;
    number = WIDTH'(12);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_nodone", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b1, 12, 1'b0);

    // Randomized operations with random idle gaps
    for (int t = 0; t < 30; t++) begin
      logic m;
      int   n, gap;
      m   = 1'($urandom_range(0, 1));
      n   = m ? int'($urandom_range(0, 20)) : int'($urandom_range(0, MAXV));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_done", 32'(done), 32'd0);
      end
      do_op(m, n, 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    chk("final_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
